// File: rtl/tdoa_pkg.sv
// Shared types and width helpers for the multi-channel TDOA correlator.
// Provides the FSM state enum and the lag/accumulator width functions.
package tdoa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        CLR,
        MAC,
        CHECK,
        OUTPUT
    } state_t;

    function automatic int lag_w(input int d);
        return $clog2(d + 1) + 1;
    endfunction

    function automatic int acc_w(input int qw, input int w);
        return 2 * qw + $clog2(w);
    endfunction

endpackage

// File: rtl/tdoa_sample_buf.sv
// Capture RAM: one reference lane plus N_MIC target lanes, QW bits each.
// Ports: clk; write we_i/waddr_i/ref_d_i/tgt_d_i; reads ref_idx_i -> ref_o,
// (tgt_ch_i, tgt_idx_i) -> tgt_o, both combinational.
module tdoa_sample_buf
    import tdoa_pkg::*;
#(
    parameter int N_MIC = 3,
    parameter int W     = 64,
    parameter int QW    = 4,
    parameter int IW    = $clog2(W),
    parameter int CW    = (N_MIC > 1) ? $clog2(N_MIC) : 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IW-1:0]         waddr_i,
    input  logic [QW-1:0]         ref_d_i,
    input  logic [N_MIC*QW-1:0]   tgt_d_i,
    input  logic [IW-1:0]         ref_idx_i,
    input  logic [CW-1:0]         tgt_ch_i,
    input  logic [IW-1:0]         tgt_idx_i,
    output logic [QW-1:0]         ref_o,
    output logic [QW-1:0]         tgt_o
);

    logic [QW-1:0] ref_mem_q [W];
    logic [QW-1:0] tgt_mem_q [N_MIC][W];

    // Plain RAM: contents are only meaningful after a full capture.
    always_ff @(posedge clk) begin
        if (we_i) begin
            ref_mem_q[waddr_i] <= ref_d_i;
            for (int c = 0; c < N_MIC; c++)
                tgt_mem_q[c][waddr_i] <= tgt_d_i[c*QW +: QW];
        end
    end

    assign ref_o = ref_mem_q[ref_idx_i];
    assign tgt_o = tgt_mem_q[tgt_ch_i][tgt_idx_i];

endmodule

// File: rtl/tdoa_multi_xcorr.sv
// Multi-mic TDOA: captures W frames, correlates each target mic against the
// reference over lags -D..+D with one shared MAC, reports best lag per mic.
// Ports: clk, rst, start, cont_mode, sample_valid, mic_ref_in, mic_in ->
// busy, delay_out, result_ready, dropped. Define TDOA_PEAK_OUT_EN to add
// peak_out (winning correlation per channel).
module tdoa_multi_xcorr
    import tdoa_pkg::*;
#(
    parameter int N_MIC = 3,
    parameter int W     = 64,
    parameter int D     = 22,
    parameter int QW    = 4,
    parameter int LW    = lag_w(D),
    parameter int ACC_W = acc_w(QW, W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   cont_mode,
    input  logic                   sample_valid,
    input  logic [15:0]            mic_ref_in,
    input  logic [N_MIC*16-1:0]    mic_in,
    output logic                   busy,
    output logic [N_MIC*LW-1:0]    delay_out,
    output logic                   result_ready,
    output logic                   dropped
`ifdef TDOA_PEAK_OUT_EN
   ,output logic [N_MIC*ACC_W-1:0] peak_out
`endif
);

    localparam int L  = W - 2 * D;
    localparam int IW = $clog2(W);
    localparam int CW = (N_MIC > 1) ? $clog2(N_MIC) : 1;
    localparam logic signed [LW-1:0]    LAG_MIN = LW'(-D);
    localparam logic signed [LW-1:0]    LAG_MAX = LW'(D);
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  state_q, state_d;
    logic [IW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [IW-1:0]           k_q, k_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic signed [LW-1:0]    lag_q, lag_d;
    logic signed [LW-1:0]    best_q, best_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] max_q, max_d;
    logic [N_MIC*LW-1:0]     slots_q, slots_d;
    logic [N_MIC*LW-1:0]     dout_q, dout_d;
    logic                    rdy_q, rdy_d;
    logic                    drop_q, drop_d;
`ifdef TDOA_PEAK_OUT_EN
    logic [N_MIC*ACC_W-1:0]  pslots_q, pslots_d;
    logic [N_MIC*ACC_W-1:0]  peak_q, peak_d;
`endif

    logic [N_MIC*QW-1:0]     tgt_q4;
    logic [QW-1:0]           ref_s, tgt_s;
    logic [IW-1:0]           ref_idx, tgt_idx;
    logic signed [2*QW-1:0]  a_x, b_x, prod;
    logic                    win;
    logic                    unused_lsbs;

    always_comb begin
        tgt_q4 = '0;
        for (int c = 0; c < N_MIC; c++)
            tgt_q4[c*QW +: QW] = mic_in[16*c+15 -: QW];
    end

    assign unused_lsbs = ^{mic_ref_in, mic_in};

    // Reference walks the central L samples; target is offset by the lag.
    assign ref_idx = IW'(int'(k_q) + D);
    assign tgt_idx = IW'(int'(k_q) + D + int'(lag_q));

    tdoa_sample_buf #(
        .N_MIC (N_MIC),
        .W     (W),
        .QW    (QW),
        .IW    (IW),
        .CW    (CW)
    ) u_buf (
        .clk       (clk),
        .we_i      (state_q == CAPTURE && sample_valid),
        .waddr_i   (wr_ptr_q),
        .ref_d_i   (mic_ref_in[15 -: QW]),
        .tgt_d_i   (tgt_q4),
        .ref_idx_i (ref_idx),
        .tgt_ch_i  (ch_q),
        .tgt_idx_i (tgt_idx),
        .ref_o     (ref_s),
        .tgt_o     (tgt_s)
    );

    // Sign-extend before multiplying so the low 2*QW bits are exact.
    assign a_x  = {{QW{ref_s[QW-1]}}, ref_s};
    assign b_x  = {{QW{tgt_s[QW-1]}}, tgt_s};
    assign prod = a_x * b_x;
    // Strict compare: on ties the earlier (more negative) lag is kept.
    assign win  = acc_q > max_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        k_d      = k_q;
        ch_d     = ch_q;
        lag_d    = lag_q;
        best_d   = best_q;
        acc_d    = acc_q;
        max_d    = max_q;
        slots_d  = slots_q;
        dout_d   = dout_q;
        rdy_d    = 1'b0;
        drop_d   = drop_q;
`ifdef TDOA_PEAK_OUT_EN
        pslots_d = pslots_q;
        peak_d   = peak_q;
`endif
        if (sample_valid && (state_q inside {CLR, MAC, CHECK, OUTPUT}))
            drop_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start || cont_mode) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                    drop_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    wr_ptr_d = wr_ptr_q + IW'(1);
                    if (wr_ptr_q == IW'(W - 1)) begin
                        state_d = CLR;
                        ch_d    = '0;
                        lag_d   = LAG_MIN;
                        best_d  = LAG_MIN;
                        max_d   = ACC_MIN;
                    end
                end
            end
            CLR: begin
                acc_d   = '0;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_W-2*QW){prod[2*QW-1]}}, prod};
                k_d   = k_q + IW'(1);
                if (k_q == IW'(L - 1))
                    state_d = CHECK;
            end
            CHECK: begin
                if (win) begin
                    max_d  = acc_q;
                    best_d = lag_q;
                end
                state_d = CLR;
                if (lag_q < LAG_MAX) begin
                    lag_d = lag_q + LW'(1);
                end else begin
                    slots_d[LW*ch_q +: LW] = win ? lag_q : best_q;
`ifdef TDOA_PEAK_OUT_EN
                    pslots_d[ACC_W*ch_q +: ACC_W] = win ? acc_q : max_q;
`endif
                    lag_d  = LAG_MIN;
                    best_d = LAG_MIN;
                    max_d  = ACC_MIN;
                    if (ch_q == CW'(N_MIC - 1))
                        state_d = OUTPUT;
                    else
                        ch_d = ch_q + CW'(1);
                end
            end
            OUTPUT: begin
                // Publish all channels at once so no partial result shows.
                dout_d = slots_q;
                rdy_d  = 1'b1;
`ifdef TDOA_PEAK_OUT_EN
                peak_d = pslots_q;
`endif
                if (cont_mode) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                    drop_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            k_q      <= '0;
            ch_q     <= '0;
            lag_q    <= '0;
            best_q   <= '0;
            acc_q    <= '0;
            max_q    <= '0;
            slots_q  <= '0;
            dout_q   <= '0;
            rdy_q    <= 1'b0;
            drop_q   <= 1'b0;
`ifdef TDOA_PEAK_OUT_EN
            pslots_q <= '0;
            peak_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            k_q      <= k_d;
            ch_q     <= ch_d;
            lag_q    <= lag_d;
            best_q   <= best_d;
            acc_q    <= acc_d;
            max_q    <= max_d;
            slots_q  <= slots_d;
            dout_q   <= dout_d;
            rdy_q    <= rdy_d;
            drop_q   <= drop_d;
`ifdef TDOA_PEAK_OUT_EN
            pslots_q <= pslots_d;
            peak_q   <= peak_d;
`endif
        end
    end

    assign busy         = state_q != IDLE;
    assign delay_out    = dout_q;
    assign result_ready = rdy_q;
    assign dropped      = drop_q;
`ifdef TDOA_PEAK_OUT_EN
    assign peak_out     = peak_q;
`endif

endmodule

// File: tb/tb_tdoa_multi_xcorr.sv
// Directed bench for tdoa_multi_xcorr: table of delay patterns plus
// hand-written sequences for continuous mode, reset abort and start-while-busy.
module tb_tdoa_multi_xcorr;

    localparam int N_MIC = 3;
    localparam int W     = 64;
    localparam int D     = 22;
    localparam int LW    = 6;
    localparam int ACC_W = 14;
    localparam int LAT   = 2971;
    localparam int BOUND = 4000;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  cont_mode;
    logic                  sample_valid;
    logic [15:0]           mic_ref_in;
    logic [N_MIC*16-1:0]   mic_in;
    logic                  busy;
    logic [N_MIC*LW-1:0]   delay_out;
    logic                  result_ready;
    logic                  dropped;
`ifdef TDOA_PEAK_OUT_EN
    logic [N_MIC*ACC_W-1:0] peak_out;
`endif

    tdoa_multi_xcorr dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cont_mode    (cont_mode),
        .sample_valid (sample_valid),
        .mic_ref_in   (mic_ref_in),
        .mic_in       (mic_in),
        .busy         (busy),
        .delay_out    (delay_out),
        .result_ready (result_ready),
        .dropped      (dropped)
`ifdef TDOA_PEAK_OUT_EN
       ,.peak_out     (peak_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t_last = 0;
    bit nz [W+2*D];

    typedef struct {
        int d0; int d1; int d2;
        bit zero;
        int e0; int e1; int e2;
    } vec_t;

    vec_t vecs [3];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // +7 / -7 in the top nibble; low bits are junk the DUT must drop.
    function automatic logic [15:0] smp(input bit zero, input bit full,
                                        input int idx);
        if (zero) return 16'h0000;
        if (full) return 16'h7FFF;
        return nz[idx] ? 16'h7ABC : 16'h9123;
    endfunction

    // Target c at time n carries the reference from time n - d_c.
    task automatic send_window(input int d0, input int d1, input int d2,
                               input bit zero, input bit full);
        int d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int n = 0; n < W; n++) begin
            sample_valid = 1'b1;
            mic_ref_in   = smp(zero, full, n + D);
            for (int c = 0; c < N_MIC; c++)
                mic_in[16*c +: 16] = smp(zero, full, n + D - d[c]);
            tick(1);
        end
        sample_valid = 1'b0;
        t_last = cyc;
    endtask

    task automatic wait_result(output int lat);
        bit seen;
        int n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < BOUND) begin
            tick(1);
            n++;
            if (result_ready) seen = 1'b1;
        end
        lat = cyc - t_last;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL result_timeout got none expected pulse within %0d", BOUND);
        end
    endtask

    task automatic chk_delays(input string name, input int e0, input int e1,
                              input int e2);
        int e [3];
        logic signed [LW-1:0] g;
        e[0] = e0; e[1] = e1; e[2] = e2;
        for (int c = 0; c < N_MIC; c++) begin
            g = delay_out[LW*c +: LW];
            chk($sformatf("%s_ch%0d", name, c), int'(g), e[c]);
        end
    endtask

    initial begin
        int lat;
        int extra;

        vecs[0] = '{5, -3, 0, 1'b0, 5, -3, 0};
        vecs[1] = '{22, -22, 0, 1'b0, 22, -22, 0};
        vecs[2] = '{9, -9, 1, 1'b1, -22, -22, -22};

        for (int i = 0; i < W + 2 * D; i++)
            nz[i] = 1'($urandom_range(0, 1));

        rst = 1'b1; start = 1'b0; cont_mode = 1'b0;
        sample_valid = 1'b0; mic_ref_in = '0; mic_in = '0;
        tick(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_delay", int'(delay_out), 0);
        chk("rst_ready", int'(result_ready), 0);
        chk("rst_dropped", int'(dropped), 0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            tick(1);
            start = 1'b0;
            chk($sformatf("v%0d_busy", i), int'(busy), 1);
            send_window(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].zero, 1'b0);
            wait_result(lat);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            chk_delays($sformatf("v%0d_delay", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
            chk($sformatf("v%0d_idle", i), int'(busy), 0);
            tick(1);
            chk($sformatf("v%0d_pulse_w", i), int'(result_ready), 0);
        end

        // Continuous mode: three back-to-back windows.
        cont_mode = 1'b1;
        tick(1);
        send_window(4, 4, 4, 1'b0, 1'b0);
        tick(10);
        sample_valid = 1'b1;
        tick(3);
        sample_valid = 1'b0;
        chk("cont_dropped_set", int'(dropped), 1);
        wait_result(lat);
        chk_delays("cont_w1", 4, 4, 4);
        chk("cont_dropped_clr", int'(dropped), 0);
        chk("cont_rearm_busy", int'(busy), 1);
        send_window(-6, -6, -6, 1'b0, 1'b0);
        wait_result(lat);
        chk_delays("cont_w2", -6, -6, -6);
        send_window(-6, -6, -6, 1'b0, 1'b0);
        cont_mode = 1'b0;
        wait_result(lat);
        chk_delays("cont_w3", -6, -6, -6);
        tick(1);
        chk("cont_end_idle", int'(busy), 0);

        // Reset in the middle of MAC discards everything at once.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_window(7, -11, 3, 1'b0, 1'b0);
        tick(500);
        sample_valid = 1'b1;
        tick(1);
        sample_valid = 1'b0;
        chk("mid_dropped", int'(dropped), 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_delay", int'(delay_out), 0);
        chk("abort_ready", int'(result_ready), 0);
        chk("abort_dropped", int'(dropped), 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Fresh run after abort, with a stray start while busy.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_window(7, -11, 3, 1'b0, 1'b0);
        tick(100);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_result(lat);
        chk("post_rst_latency", lat, LAT);
        chk_delays("post_rst", 7, -11, 3);
        extra = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (result_ready) extra++;
            if (busy) extra++;
        end
        chk("no_extra_result", extra, 0);

`ifdef TDOA_PEAK_OUT_EN
        start = 1'b1;
        tick(1);
        start = 1'b0;
        send_window(0, 0, 0, 1'b0, 1'b1);
        wait_result(lat);
        chk_delays("full", -22, -22, -22);
        for (int c = 0; c < N_MIC; c++)
            chk($sformatf("peak_ch%0d", c),
                int'($signed(peak_out[ACC_W*c +: ACC_W])), 980);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
